// File: rtl/spi3w_reg_responder.sv
// 3-wire SPI responder (CPOL=0, MSB first, 16-bit header, streaming data) backed by
// an 8-bit register file, oversampled in the clk_20 domain with a fabric read port.
module spi3w_reg_responder #(
    parameter int REG_ADDR_W  = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_20,
    input  logic                  rst,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_sdi,
    output logic                  spi_sdo,
    output logic                  spi_sdo_oe,
    input  logic [REG_ADDR_W-1:0] i_host_raddr,
    output logic [7:0]            o_host_rdata,
    output logic                  o_wr_strb,
    output logic [12:0]           o_wr_addr,
    output logic [7:0]            o_wr_data,
    output logic                  o_frame_done,
    output logic                  o_frame_err
);

    localparam logic [1:0] ST_WAIT_CS = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_HDR     = 2'd2;
    localparam logic [1:0] ST_DATA    = 2'd3;

    localparam int unsigned DEPTH = 2 ** REG_ADDR_W;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, sdi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [7:0]  mem [DEPTH];
    logic [1:0]  state;
    logic [14:0] hdr_sr;
    logic [4:0]  bit_cnt;
    logic        rw;
    logic [12:0] addr;
    logic [7:0]  sh;
    logic        byte_ok;
    logic        wr_pend;

    logic [12:0] hdr_addr, next_addr;
    logic [7:0]  hdr_rd, next_rd;

    // Sync chains reset low so cs_n must genuinely be seen high before a frame can start.
    always_ff @(posedge clk_20 or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            sdi_sync  <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    assign hdr_addr  = {hdr_sr[11:0], sdi_s};
    assign next_addr = addr - 13'd1;
    assign hdr_rd    = ((hdr_addr >> REG_ADDR_W) == '0) ? mem[hdr_addr[REG_ADDR_W-1:0]] : '0;
    assign next_rd   = ((next_addr >> REG_ADDR_W) == '0) ? mem[next_addr[REG_ADDR_W-1:0]] : '0;

    always_ff @(posedge clk_20 or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i[REG_ADDR_W-1:0]] <= '0;
            state        <= ST_WAIT_CS;
            hdr_sr       <= '0;
            bit_cnt      <= '0;
            rw           <= 1'b0;
            addr         <= '0;
            sh           <= '0;
            byte_ok      <= 1'b0;
            wr_pend      <= 1'b0;
            spi_sdo      <= 1'b0;
            spi_sdo_oe   <= 1'b0;
            o_host_rdata <= '0;
            o_wr_strb    <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_wr_strb    <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
            o_host_rdata <= mem[i_host_raddr];

            // cs_n release outranks any sclk edge detected in the same cycle.
            if (cs_rise && (state == ST_HDR || state == ST_DATA)) begin
                spi_sdo_oe <= 1'b0;
                spi_sdo    <= 1'b0;
                wr_pend    <= 1'b0;
                bit_cnt    <= '0;
                state      <= ST_IDLE;
                if (byte_ok && bit_cnt == 5'd0) o_frame_done <= 1'b1;
                else                            o_frame_err  <= 1'b1;
            end else begin
                case (state)
                    ST_WAIT_CS: if (cs_s) state <= ST_IDLE;
                    ST_IDLE: begin
                        bit_cnt <= '0;
                        byte_ok <= 1'b0;
                        if (cs_fall) state <= ST_HDR;
                    end
                    ST_HDR: if (sclk_rise) begin
                        hdr_sr <= {hdr_sr[13:0], sdi_s};
                        if (bit_cnt == 5'd15) begin
                            rw      <= hdr_sr[14];
                            addr    <= hdr_addr;
                            sh      <= hdr_rd;
                            bit_cnt <= '0;
                            state   <= ST_DATA;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    default: begin
                        if (wr_pend) begin
                            if ((addr >> REG_ADDR_W) == '0) mem[addr[REG_ADDR_W-1:0]] <= sh;
                            o_wr_strb <= 1'b1;
                            o_wr_addr <= addr;
                            o_wr_data <= sh;
                            addr      <= next_addr;
                            bit_cnt   <= '0;
                            byte_ok   <= 1'b1;
                            wr_pend   <= 1'b0;
                        end else if (rw) begin
                            if (sclk_fall) begin
                                spi_sdo_oe <= 1'b1;
                                spi_sdo    <= sh[7];
                                sh         <= {sh[6:0], 1'b0};
                            end else if (sclk_rise) begin
                                if (bit_cnt == 5'd7) begin
                                    sh      <= next_rd;
                                    addr    <= next_addr;
                                    bit_cnt <= '0;
                                    byte_ok <= 1'b1;
                                end else begin
                                    bit_cnt <= bit_cnt + 5'd1;
                                end
                            end
                        end else if (sclk_rise) begin
                            sh      <= {sh[6:0], sdi_s};
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) wr_pend <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi3w_reg_responder.sv
// Self-checking bench for spi3w_reg_responder: directed frame table, corner-case
// sequences and random frames compared against a register-file model.
module tb_spi3w_reg_responder;

    logic        clk_20 = 1'b0;
    logic        rst, spi_sclk, spi_cs_n, spi_sdi;
    logic        spi_sdo, spi_sdo_oe;
    logic [6:0]  i_host_raddr;
    logic [7:0]  o_host_rdata;
    logic        o_wr_strb;
    logic [12:0] o_wr_addr;
    logic [7:0]  o_wr_data;
    logic        o_frame_done, o_frame_err;

    always #5 clk_20 = ~clk_20;

    spi3w_reg_responder #(.REG_ADDR_W(7), .SYNC_STAGES(2)) dut (
        .clk_20(clk_20), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_sdi(spi_sdi), .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
        .i_host_raddr(i_host_raddr), .o_host_rdata(o_host_rdata),
        .o_wr_strb(o_wr_strb), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_frame_done(o_frame_done), .o_frame_err(o_frame_err)
    );

    typedef struct {
        logic [15:0] hdr;
        int unsigned nbytes;
        logic [31:0] wb;
        logic [31:0] exp_rd;
        int unsigned exp_strb;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned half     = 6;
    logic [7:0]  model [128];
    logic [20:0] strb_q [$];
    logic [20:0] exp_q [$];
    int unsigned n_done, n_err;
    logic [7:0]  strb_rdata;

    always @(negedge clk_20) begin
        if (o_wr_strb === 1'b1) begin
            strb_q.push_back({o_wr_addr, o_wr_data});
            strb_rdata = o_host_rdata;
        end
        if (o_frame_done === 1'b1) n_done++;
        if (o_frame_err === 1'b1) n_err++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic spi_bit(input logic b, output logic s, output logic oe);
        @(negedge clk_20);
        spi_sclk = 1'b0;
        spi_sdi  = b;
        repeat (half) @(negedge clk_20);
        s  = spi_sdo;
        oe = spi_sdo_oe;
        spi_sclk = 1'b1;
        repeat (half) @(negedge clk_20);
    endtask

    task automatic end_frame();
        @(negedge clk_20);
        spi_sclk = 1'b0;
        repeat (half) @(negedge clk_20);
        spi_cs_n = 1'b1;
        repeat (half + 4) @(negedge clk_20);
    endtask

    task automatic do_frame(input logic [15:0] hdr, input int unsigned nbits, input logic [31:0] wb,
                            output logic [31:0] rb, output int unsigned oe_hdr, output int unsigned oe_dat_lo);
        logic [47:0] stream;
        logic s, oe;
        stream = {hdr, wb};
        rb = '0;
        oe_hdr = 0;
        oe_dat_lo = 0;
        strb_q.delete();
        n_done = 0;
        n_err  = 0;
        @(negedge clk_20);
        spi_cs_n = 1'b0;
        repeat (half) @(negedge clk_20);
        for (int unsigned i = 0; i < nbits; i++) begin
            spi_bit(stream[47-i], s, oe);
            if (i < 16) begin
                if (oe) oe_hdr++;
            end else begin
                rb[31-(i-16)] = s;
                if (!oe) oe_dat_lo++;
            end
        end
        end_frame();
    endtask

    // Expected behaviour from the protocol rules: byte j touches address (A - j) mod 8192.
    task automatic model_frame(input logic [15:0] hdr, input int unsigned nbytes, input logic [31:0] wb,
                               output logic [31:0] exp_rb);
        int unsigned a;
        logic [7:0] d;
        exp_q.delete();
        exp_rb = '0;
        for (int unsigned j = 0; j < nbytes; j++) begin
            a = ({19'd0, hdr[12:0]} + 32'd8192 - j) % 32'd8192;
            d = wb[31-8*j -: 8];
            if (hdr[15]) begin
                exp_rb[31-8*j -: 8] = (a < 128) ? model[a] : 8'h00;
            end else begin
                exp_q.push_back({a[12:0], d});
                if (a < 128) model[a] = d;
            end
        end
    endtask

    task automatic run_frame(input logic [15:0] hdr, input int unsigned nbytes, input logic [31:0] wb,
                             output logic [31:0] rb);
        logic [31:0] erb;
        int unsigned oh, odl;
        model_frame(hdr, nbytes, wb, erb);
        do_frame(hdr, 16 + 8*nbytes, wb, rb, oh, odl);
        check("strobe_count", strb_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < strb_q.size(); k++)
            check("strobe_addr_data", {11'd0, strb_q[k]}, {11'd0, exp_q[k]});
        check("frame_done", n_done, 1);
        check("frame_err", n_err, 0);
        check("oe_in_header", oh, 0);
        if (hdr[15]) begin
            check("read_data", rb, erb);
            check("oe_in_data", odl, 0);
        end
        check("oe_after_cs", {31'd0, spi_sdo_oe}, 0);
    endtask

    task automatic host_chk(input logic [6:0] a, input logic [7:0] e);
        @(negedge clk_20);
        i_host_raddr = a;
        @(negedge clk_20);
        check("host_rdata", {24'd0, o_host_rdata}, {24'd0, e});
    endtask

    task automatic model_clear();
        for (int i = 0; i < 128; i++) model[i] = 8'h00;
    endtask

    vec_t        tbl [8];
    logic [31:0] rb;
    int unsigned oh, odl;
    logic [7:0]  old;
    logic        s, oe;
    logic [47:0] stream;
    logic [12:0] ra;
    logic [15:0] rh;

    initial begin
        tbl[0] = '{16'h0010, 1, 32'hA500_0000, 32'h0, 1};
        tbl[1] = '{16'h8010, 1, 32'h0, 32'hA500_0000, 0};
        tbl[2] = '{16'h0005, 3, 32'h1122_3300, 32'h0, 3};
        tbl[3] = '{16'h8005, 3, 32'h0, 32'h1122_3300, 0};
        tbl[4] = '{16'h0000, 2, 32'hAABB_0000, 32'h0, 2};
        tbl[5] = '{16'h8001, 3, 32'h0, 32'h00AA_0000, 0};
        tbl[6] = '{16'h6003, 1, 32'h5A00_0000, 32'h0, 1};
        tbl[7] = '{16'h8003, 2, 32'h0, 32'h5A00_0000, 0};

        model_clear();
        rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_sdi = 1'b0; i_host_raddr = '0;
        repeat (3) @(negedge clk_20);
        check("reset_ctrl", {27'd0, spi_sdo, spi_sdo_oe, o_wr_strb, o_frame_done, o_frame_err}, 0);
        check("reset_data", {3'd0, o_wr_addr, o_wr_data, o_host_rdata}, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk_20);

        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].hdr, tbl[i].nbytes, tbl[i].wb, rb);
            check("tbl_strobes", strb_q.size(), tbl[i].exp_strb);
            if (tbl[i].hdr[15]) check("tbl_rdata", rb, tbl[i].exp_rd);
        end
        host_chk(7'h10, 8'hA5);
        host_chk(7'h05, 8'h11);
        host_chk(7'h04, 8'h22);
        host_chk(7'h03, 8'h5A);
        host_chk(7'h00, 8'hAA);
        host_chk(7'h7F, 8'h00);

        // cs_n released four bits into the data byte
        do_frame(16'h0020, 20, 32'hF000_0000, rb, oh, odl);
        check("partial_byte_err", n_err, 1);
        check("partial_byte_done", n_done, 0);
        check("partial_byte_strb", strb_q.size(), 0);
        host_chk(7'h20, 8'h00);
        run_frame(16'h0020, 1, 32'h7700_0000, rb);
        host_chk(7'h20, 8'h77);

        // cs_n released mid-header
        do_frame(16'h8010, 10, 32'h0, rb, oh, odl);
        check("partial_hdr_err", n_err, 1);
        check("partial_hdr_done", n_done, 0);

        // host read of the address being written in the commit cycle sees the old value
        old = model[16];
        @(negedge clk_20);
        i_host_raddr = 7'h10;
        run_frame(16'h0010, 1, 32'h3C00_0000, rb);
        check("read_before_write", {24'd0, strb_rdata}, {24'd0, old});
        host_chk(7'h10, 8'h3C);

        // reset in the middle of a read frame
        strb_q.delete(); n_done = 0; n_err = 0;
        stream = {16'h8010, 32'h0};
        @(negedge clk_20);
        spi_cs_n = 1'b0;
        repeat (half) @(negedge clk_20);
        for (int unsigned i = 0; i < 19; i++) spi_bit(stream[47-i], s, oe);
        check("oe_before_rst", {31'd0, oe}, 1);
        @(negedge clk_20);
        rst = 1'b1;
        #1;
        check("oe_at_rst", {31'd0, spi_sdo_oe}, 0);
        @(negedge clk_20);
        rst = 1'b0;
        model_clear();
        oh = 0;
        for (int unsigned i = 0; i < 13; i++) begin
            spi_bit(1'($urandom_range(0, 1)), s, oe);
            if (oe) oh++;
        end
        end_frame();
        check("post_rst_oe", oh, 0);
        check("post_rst_pulses", n_done + n_err + strb_q.size(), 0);
        host_chk(7'h05, 8'h00);
        run_frame(16'h0010, 1, 32'h4200_0000, rb);
        run_frame(16'h8011, 2, 32'h0, rb);

        // random frames against the model
        for (int n = 0; n < 24; n++) begin
            half = $urandom_range(5, 8);
            if ($urandom_range(0, 3) == 0) ra = 13'($urandom);
            else                           ra = 13'($urandom_range(0, 127));
            rh = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra};
            run_frame(rh, $urandom_range(1, 4), $urandom, rb);
        end
        half = 6;
        for (int n = 0; n < 8; n++) begin
            ra = 13'($urandom_range(0, 127));
            host_chk(ra[6:0], model[ra[6:0]]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
